// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 16x-oversampled LSB-first UART receiver with its own baud tick.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_err port.
module uart_rx_unit #(
  parameter int NB_DATA   = 8,
  parameter int SB_TICK   = 16,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data_rx,
  output logic               o_rx_done,
  output logic               o_frame_err,
  output logic               o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic               o_parity_err
`endif
);

  localparam int DIVISOR = CLK_FREQ / (BAUD_RATE * 16);
  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  if (DIVISOR < 1) begin : g_div_chk
    $error("uart_rx_unit: CLK_FREQ too low for BAUD_RATE*16");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic [CW-1:0]      cnt_q;
  logic               tick;
  logic [1:0]         sync_q;
  logic               rx_s;
  state_t             state_q;
  logic [3:0]         s_q;
  logic [NW-1:0]      n_q;
  logic [NB_DATA-1:0] shift_q;
  logic [NB_DATA-1:0] data_q;
  logic               done_q;
  logic               ferr_q;
`ifdef UART_RX_PARITY_EN
  logic               perr_q;
  logic               pbad_q;
`endif

  assign tick = (cnt_q == CW'(DIVISOR - 1));
  assign rx_s = sync_q[1];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Preset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_rx};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '1;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q <= S_START;
            s_q     <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (s_q == 4'd7) begin
              if (!rx_s) begin
                state_q <= S_DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (s_q == 4'd15) begin
              shift_q <= {rx_s, shift_q[NB_DATA-1:1]};
              s_q     <= '0;
              if (n_q == NW'(NB_DATA - 1)) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            if (s_q == 4'd15) begin
              s_q     <= '0;
              state_q <= S_STOP;
              if (rx_s != ^shift_q) begin
                perr_q <= 1'b1;
                pbad_q <= 1'b1;
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (s_q == 4'(SB_TICK - 1)) begin
`ifdef UART_RX_PARITY_EN
              pbad_q <= 1'b0;
`endif
              if (rx_s) begin
                state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                if (!pbad_q) begin
                  data_q <= shift_q;
                  done_q <= 1'b1;
                end
`else
                data_q <= shift_q;
                done_q <= 1'b1;
`endif
              end else begin
                ferr_q  <= 1'b1;
                state_q <= S_BREAK;
              end
            end else begin
              s_q <= s_q + 4'd1;
            end
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data_rx   = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: frame-level model of the receiver; every frame's expected
// outcome is queued by the driver and matched against output pulses each cycle.
module tb_uart_rx_unit;

  localparam int BIT = 160;
  localparam logic [31:0] K_DONE = 32'h100;
  localparam logic [31:0] K_FERR = 32'h200;
  localparam logic [31:0] K_PERR = 32'h300;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_rx;
  logic [7:0] o_data_rx;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] evq[$];
  logic [7:0]  last_exp = 8'h00;
  logic [31:0] cmp_ev;
  bit          prev_done = 0;
  bit          prev_ferr = 0;

  always #5 clk = ~clk;

  uart_rx_unit #(
    .NB_DATA(8),
    .SB_TICK(16),
    .CLK_FREQ(1_600_000),
    .BAUD_RATE(10_000)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_rx(i_rx),
    .o_data_rx(o_data_rx),
    .o_rx_done(o_rx_done),
    .o_frame_err(o_frame_err),
    .o_busy(o_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(o_parity_err)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pop_ev();
    if (evq.size() == 0) return 32'h0;
    return evq.pop_front();
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (o_rx_done) begin
        cmp_ev = pop_ev();
        chk("rx_done_event", K_DONE | 32'(o_data_rx), cmp_ev);
        if (cmp_ev[9:8] == 2'd1) last_exp = cmp_ev[7:0];
      end
      if (o_frame_err) begin
        cmp_ev = pop_ev();
        chk("frame_err_event", K_FERR, cmp_ev);
      end
`ifdef UART_RX_PARITY_EN
      if (o_parity_err) begin
        cmp_ev = pop_ev();
        chk("parity_err_event", K_PERR, cmp_ev);
      end
`endif
      chk("data_hold", 32'(o_data_rx), 32'(last_exp));
      chk("done_ferr_excl", 32'(o_rx_done & o_frame_err), 0);
      chk("done_width", 32'(o_rx_done & prev_done), 0);
      chk("ferr_width", 32'(o_frame_err & prev_ferr), 0);
      prev_done = o_rx_done;
      prev_ferr = o_frame_err;
    end else begin
      prev_done = 0;
      prev_ferr = 0;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic line(input logic v, input int clks);
    i_rx = v;
    wclk(clks);
  endtask

  // hold: extra bit times the line stays low after a bad stop bit
  task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                            input int hold, input bit pflip);
    bit pbad;
    pbad = HAS_PAR && pflip;
    if (pbad) evq.push_back(K_PERR);
    if (!stop_ok) evq.push_back(K_FERR);
    else if (!pbad) evq.push_back(K_DONE | 32'(d));
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(d[i], BIT);
    if (HAS_PAR) line(^d ^ pflip, BIT);
    if (stop_ok) begin
      line(1'b1, BIT);
    end else begin
      line(1'b0, BIT * (1 + hold));
      line(1'b1, BIT);
    end
    chk("frame_events_seen", evq.size(), 0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_data"}, 32'(o_data_rx), 0);
    chk({nm, "_done"}, 32'(o_rx_done), 0);
    chk({nm, "_ferr"}, 32'(o_frame_err), 0);
    chk({nm, "_busy"}, 32'(o_busy), 0);
`ifdef UART_RX_PARITY_EN
    chk({nm, "_perr"}, 32'(o_parity_err), 0);
`endif
  endtask

  initial begin
    logic [7:0] pd;
    rst_n = 1'b0;
    i_rx  = 1'b1;
    wclk(5);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    wclk(40);
    chk("post_reset_busy", 32'(o_busy), 0);

    send_frame(8'h00, 1, 0, 0);
    line(1'b1, 40);
    chk("t1_data0", 32'(o_data_rx), 32'h00);
    send_frame(8'h01, 1, 0, 0);
    line(1'b1, 40);
    chk("t1_data1", 32'(o_data_rx), 32'h01);

    send_frame(8'hA5, 1, 0, 0);
    fork
      send_frame(8'h3C, 1, 0, 0);
      begin
        wclk(800);
        chk("t2_busy_mid", 32'(o_busy), 1);
      end
    join
    line(1'b1, 100);
    chk("t2_busy_end", 32'(o_busy), 0);
    chk("t2_data", 32'(o_data_rx), 32'h3C);

    line(1'b0, 60);
    line(1'b1, 200);
    chk("t3_glitch_busy", 32'(o_busy), 0);
    chk("t3_glitch_data", 32'(o_data_rx), 32'h3C);
    send_frame(8'h5A, 1, 0, 0);
    line(1'b1, 40);
    chk("t3_data", 32'(o_data_rx), 32'h5A);

    send_frame(8'h7E, 0, 2, 0);
    chk("t4_data_held", 32'(o_data_rx), 32'h5A);
    line(1'b1, 100);
    send_frame(8'h81, 1, 0, 0);
    line(1'b1, 40);
    chk("t4_data", 32'(o_data_rx), 32'h81);

    pd = 8'h99;
    line(1'b0, BIT);
    for (int i = 0; i < 4; i++) line(pd[i], BIT);
    wclk(50);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t5_midrst");
    evq.delete();
    last_exp = 8'h00;
    i_rx = 1'b1;
    wclk(5);
    rst_n = 1'b1;
    line(1'b1, 200);
    send_frame(8'hC3, 1, 0, 0);
    line(1'b1, 40);
    chk("t5_data", 32'(o_data_rx), 32'hC3);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1, 0, 1);
    line(1'b1, 40);
    chk("t6_bad_par_data", 32'(o_data_rx), 32'hC3);
    send_frame(8'h07, 1, 0, 0);
    line(1'b1, 40);
    chk("t6_data", 32'(o_data_rx), 32'h07);
`endif

    for (int k = 0; k < 16; k++) begin
      logic [7:0] d;
      bit         good;
      d    = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 5) == 0) begin
        line(1'b0, $urandom_range(10, 60));
        line(1'b1, 150);
      end
      send_frame(d, good, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      line(1'b1, $urandom_range(0, 200));
    end

    line(1'b1, 400);
    chk("final_busy", 32'(o_busy), 0);
    chk("final_queue", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
